mode_btn_encoder: RTL



---
 rtl/mode_btn_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mode_btn_encoder.sv
// Mode pushbutton encoder: synchronises and debounces one button, then turns short/long presses into a 2-bit mode code.
// Optional MODE_LOCK_EN adds a mode_lock input that freezes the mode while it is high.
module mode_btn_encoder #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 100000000,
  parameter int CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
`ifdef MODE_LOCK_EN
  input  logic       mode_lock,
`endif
  output logic [1:0] mode_code,
  output logic       mode_chg,
  output logic       btn_db
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  logic             sync1;
  logic             btn_s;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  state_t           state;
  state_t           state_nxt;
  logic [1:0]       mode_nxt;
  logic             chg_nxt;
  logic             lock_act;

`ifdef MODE_LOCK_EN
  assign lock_act = mode_lock;
`else
  assign lock_act = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_mode;
      btn_s <= sync1;
    end
  end

  // The debounced level only follows btn_s after it has disagreed for DEBOUNCE_CYC straight cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      btn_db <= btn_s;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      mode_code <= 2'b00;
      mode_chg  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      mode_code <= mode_nxt;
      mode_chg  <= chg_nxt;
    end
  end

  // Only PRESSED counts, so hold_cnt simply stops at LONG_LAST once the press goes long.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    mode_nxt  = mode_code;
    chg_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_db) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
        end
      end
      PRESSED: begin
        if (!btn_db) begin
          state_nxt = IDLE;
          if (!lock_act) begin
            chg_nxt = 1'b1;
            case (mode_code)
              2'b00:   mode_nxt = 2'b01;
              2'b01:   mode_nxt = 2'b10;
              default: mode_nxt = 2'b00;
            endcase
          end
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          if (!lock_act) begin
            mode_nxt = 2'b00;
            chg_nxt  = (mode_code != 2'b00);
          end
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!btn_db) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
